// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 constants and fetch-stage bundle types.
// Imported by fetch_unit and fetch_buf.
package rv32_pkg;

  localparam int XLEN = 32;
  localparam int FB_CNT_W = 3;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_ALIGN = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_plus4(
    input logic [XLEN-1:0] pc
  );
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: small synchronous FIFO of fetch entries.
// Single-cycle flush; push and pop may coincide.
module fetch_buf
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                push,
  input  fetch_entry_t        push_data,
  input  logic                pop,
  output fetch_entry_t        head,
  output logic                empty,
  output logic [FB_CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  fetch_entry_t        mem [DEPTH];
  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       wr_ptr;
  logic [FB_CNT_W-1:0] cnt_q;
  logic [FB_CNT_W-1:0] cnt_d;
  logic                do_pop;

  function automatic logic [AW-1:0] bump(
    input logic [AW-1:0] p
  );
    return (p == LAST) ? '0 : p + AW'(1);
  endfunction

  assign empty  = (cnt_q == '0);
  assign do_pop = pop && !empty;
  assign head   = mem[rd_ptr];
  assign count  = cnt_q;

  // Entry storage; data needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Occupancy change for this cycle.
  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      (push && !do_pop): cnt_d = cnt_q + FB_CNT_W'(1);
      (do_pop && !push): cnt_d = cnt_q - FB_CNT_W'(1);
      default: ;
    endcase
  end

  // Pointers and count; flush empties in one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= bump(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: credit-based instruction fetch with redirect flush.
// Optional FETCH_MISALIGN_EN adds a sticky misalign_o flag.
module fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            stall_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            valid_f_o,
  output logic [XLEN-1:0] instr_f_o,
  output logic [XLEN-1:0] pc_f_o,
  output logic [XLEN-1:0] pcplus4_f_o
`ifdef FETCH_MISALIGN_EN
  ,
  output logic            misalign_o
`endif
);

  localparam int SUM_W = FB_CNT_W + 1;
  localparam logic [SUM_W-1:0] DEPTH_C = SUM_W'(BUF_DEPTH);

  logic [XLEN-1:0]     fetch_pc_q;
  logic [XLEN-1:0]     fetch_pc_d;
  logic [XLEN-1:0]     redir_pc;
  logic [FB_CNT_W-1:0] outs_q;
  logic [FB_CNT_W-1:0] outs_d;
  logic [FB_CNT_W-1:0] disc_q;
  logic [FB_CNT_W-1:0] disc_d;
  logic [FB_CNT_W-1:0] live;
  logic [FB_CNT_W-1:0] buf_cnt;
  logic [SUM_W-1:0]    credit_used;
  logic                mis_q;
  logic                grant;
  logic                rsp_ok;
  logic                push;
  logic                pop;
  logic                buf_empty;
  fetch_entry_t        push_e;
  fetch_entry_t        head_e;

`ifdef FETCH_MISALIGN_EN
  assign redir_pc   = redirect_pc_i;
  assign misalign_o = mis_q;

  // Sticky flag: set by unaligned redirect, cleared by aligned one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mis_q <= 1'b0;
    end else if (redirect_i) begin
      mis_q <= |redirect_pc_i[1:0];
    end
  end
`else
  assign redir_pc = redirect_pc_i & PC_ALIGN;
  assign mis_q    = 1'b0;
`endif

  // Discarded-but-pending responses still hold a credit.
  assign credit_used = SUM_W'(outs_q) + SUM_W'(buf_cnt);

  assign imem_req_o  = rst_n && !redirect_i && !mis_q
                    && (credit_used < DEPTH_C);
  assign imem_addr_o = fetch_pc_q;
  assign grant       = imem_req_o && imem_gnt_i;

  // A stray rvalid with nothing pending is ignored.
  assign rsp_ok = imem_rvalid_i && (outs_q != '0);

  // Oldest live request sits 'live' words behind fetch_pc.
  assign live         = outs_q - disc_q;
  assign push_e.instr = imem_rdata_i;
  assign push_e.pc    = fetch_pc_q - XLEN'({live, 2'b00});

  assign push = rsp_ok && !redirect_i && (disc_q == '0);
  assign pop  = !buf_empty && !stall_i && !redirect_i;

  // Next fetch address and counters; redirect wins.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    outs_d     = outs_q;
    disc_d     = disc_q;
    unique case (1'b1)
      redirect_i: begin
        fetch_pc_d = redir_pc;
        outs_d     = outs_q - FB_CNT_W'(rsp_ok);
        disc_d     = outs_d;
      end
      default: begin
        if (grant) begin
          fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
        outs_d = outs_q + FB_CNT_W'(grant)
               - FB_CNT_W'(rsp_ok);
        if (rsp_ok && (disc_q != '0)) begin
          disc_d = disc_q - FB_CNT_W'(1);
        end
      end
    endcase
  end

  // Fetch state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      outs_q     <= '0;
      disc_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outs_q     <= outs_d;
      disc_q     <= disc_d;
    end
  end

  fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_i),
    .push      (push),
    .push_data (push_e),
    .pop       (pop),
    .head      (head_e),
    .empty     (buf_empty),
    .count     (buf_cnt)
  );

  assign valid_f_o   = !buf_empty;
  assign instr_f_o   = buf_empty ? NOP_INSTR : head_e.instr;
  assign pc_f_o      = buf_empty ? '0 : head_e.pc;
  assign pcplus4_f_o = buf_empty ? '0 : pc_plus4(head_e.pc);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch bench with queue-based memory
// and pipeline model; optional FETCH_MISALIGN_EN scenario.
module tb_fetch_unit;
  import rv32_pkg::*;

  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } req_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        valid_f_o;
  logic [31:0] instr_f_o;
  logic [31:0] pc_f_o;
  logic [31:0] pcplus4_f_o;
`ifdef FETCH_MISALIGN_EN
  logic        misalign_o;
  logic        u2_mis;
`endif

  logic        u2_rst_n;
  logic        u2_req;
  logic [31:0] u2_addr;
  logic        u2_rvalid;
  logic [31:0] u2_rdata;
  logic        u2_valid;
  logic [31:0] u2_instr;
  logic [31:0] u2_pc;
  logic [31:0] u2_pc4;

  int checks;
  int failures;
  int cyc_n;
  int lat_min;
  int lat_max;
  int last_due;
  bit m_mis;
  logic [31:0]  m_pc;
  req_t         m_pend [$];
  rsp_t         m_rsp [$];
  fetch_entry_t m_buf [$];
  logic [31:0]  popped [$];

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .stall_i       (stall_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .valid_f_o     (valid_f_o),
    .instr_f_o     (instr_f_o),
    .pc_f_o        (pc_f_o),
    .pcplus4_f_o   (pcplus4_f_o)
`ifdef FETCH_MISALIGN_EN
    ,
    .misalign_o    (misalign_o)
`endif
  );

  fetch_unit #(
    .RESET_PC  (32'hFFFF_FFF8),
    .BUF_DEPTH (3)
  ) u2 (
    .clk           (clk),
    .rst_n         (u2_rst_n),
    .redirect_i    (1'b0),
    .redirect_pc_i (32'h0),
    .stall_i       (1'b0),
    .imem_req_o    (u2_req),
    .imem_addr_o   (u2_addr),
    .imem_gnt_i    (1'b1),
    .imem_rvalid_i (u2_rvalid),
    .imem_rdata_i  (u2_rdata),
    .valid_f_o     (u2_valid),
    .instr_f_o     (u2_instr),
    .pc_f_o        (u2_pc),
    .pcplus4_f_o   (u2_pc4)
`ifdef FETCH_MISALIGN_EN
    ,
    .misalign_o    (u2_mis)
`endif
  );

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Always-granting memory with one-cycle latency for u2.
  always @(posedge clk) begin
    if (!u2_rst_n) begin
      u2_rvalid <= 1'b0;
    end else begin
      u2_rvalid <= u2_req;
      u2_rdata  <= memfn(u2_addr);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // One clock of stimulus, checks and model update.
  task automatic cyc(input bit redir, input logic [31:0] tgt,
                     input bit stall, input int gprob);
    bit           rv;
    bit           g;
    bit           exp_req;
    int           due;
    logic [31:0]  exp_p4;
    fetch_entry_t e;
    fetch_entry_t e2;
    req_t         r;
    rsp_t         rs;
    redirect_i    = redir;
    redirect_pc_i = tgt;
    stall_i       = stall;
    rv = (m_rsp.size() > 0) && (m_rsp[0].due <= cyc_n);
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? m_rsp[0].data : $urandom;
    imem_gnt_i    = ($urandom_range(99) < gprob);
    #1;
    g = imem_req_o && imem_gnt_i;
    #1;
    exp_req = !redir && !m_mis
           && (m_pend.size() + m_buf.size() < DEPTH);
    checks++;
    if (imem_req_o !== exp_req) begin
      failures++;
      $display("FAIL req cyc=%0d got=%b exp=%b",
               cyc_n, imem_req_o, exp_req);
    end
    if (exp_req) begin
      checks++;
      if (imem_addr_o !== m_pc) begin
        failures++;
        $display("FAIL addr cyc=%0d got=%h exp=%h",
                 cyc_n, imem_addr_o, m_pc);
      end
    end
    checks++;
    if (valid_f_o !== (m_buf.size() != 0)) begin
      failures++;
      $display("FAIL valid cyc=%0d got=%b exp=%b",
               cyc_n, valid_f_o, m_buf.size() != 0);
    end
    if (m_buf.size() != 0) begin
      e = m_buf[0];
      exp_p4 = e.pc + 32'd4;
    end else begin
      e.instr = NOP_INSTR;
      e.pc = 32'h0;
      exp_p4 = 32'h0;
    end
    checks++;
    if (instr_f_o !== e.instr || pc_f_o !== e.pc
        || pcplus4_f_o !== exp_p4) begin
      failures++;
      $display("FAIL head cyc=%0d got=%h/%h/%h exp=%h/%h/%h",
               cyc_n, instr_f_o, pc_f_o, pcplus4_f_o,
               e.instr, e.pc, exp_p4);
    end
`ifdef FETCH_MISALIGN_EN
    checks++;
    if (misalign_o !== m_mis) begin
      failures++;
      $display("FAIL misalign cyc=%0d got=%b exp=%b",
               cyc_n, misalign_o, m_mis);
    end
`endif
    if (rv) begin
      void'(m_rsp.pop_front());
      r = m_pend.pop_front();
    end
    if (redir) begin
      m_buf.delete();
      foreach (m_pend[i]) m_pend[i].stale = 1'b1;
`ifdef FETCH_MISALIGN_EN
      m_pc  = tgt;
      m_mis = (tgt[1:0] != 2'b00);
`else
      m_pc  = tgt & 32'hFFFF_FFFC;
`endif
    end else begin
      if (!stall && m_buf.size() != 0) begin
        e2 = m_buf.pop_front();
        popped.push_back(e2.pc);
      end
      if (rv && !r.stale) begin
        e2.instr = memfn(r.pc);
        e2.pc    = r.pc;
        m_buf.push_back(e2);
      end
      if (g) begin
        due = cyc_n + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        rs.data = memfn(imem_addr_o);
        rs.due  = due;
        m_rsp.push_back(rs);
        r.pc    = m_pc;
        r.stale = 1'b0;
        m_pend.push_back(r);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    stall_i       = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    #1;
    checks++;
    if (imem_req_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_req got=%b exp=0", imem_req_o);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (valid_f_o !== 1'b0 || instr_f_o !== NOP_INSTR
        || pc_f_o !== 32'h0 || pcplus4_f_o !== 32'h0
        || imem_req_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_out got=%b/%h/%h/%h/%b exp=0/%h/0/0/0",
               valid_f_o, instr_f_o, pc_f_o, pcplus4_f_o,
               imem_req_o, NOP_INSTR);
    end
    m_pend.delete();
    m_rsp.delete();
    m_buf.delete();
    m_pc     = 32'h0;
    m_mis    = 1'b0;
    last_due = cyc_n;
    rst_n    = 1'b1;
    #1;
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      failures++;
      $display("FAIL first_req got=%b/%h exp=1/00000000",
               imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp [4];
    test_reset();
    lat_min = 1;
    lat_max = 1;
    popped.delete();
    repeat (20) cyc(1'b0, 32'h0, 1'b0, 100);
    exp[0] = 32'h0;
    exp[1] = 32'h4;
    exp[2] = 32'h8;
    exp[3] = 32'hC;
    checks++;
    if (popped.size() < 4) begin
      failures++;
      $display("FAIL stream_len got=%0d exp>=4", popped.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (popped[i] !== exp[i]) begin
          failures++;
          $display("FAIL stream_pc%0d got=%h exp=%h",
                   i, popped[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] snap_pc;
    logic [31:0] snap_in;
    test_reset();
    lat_min = 1;
    lat_max = 2;
    repeat (6) cyc(1'b0, 32'h0, 1'b1, 100);
    checks++;
    if (valid_f_o !== 1'b1) begin
      failures++;
      $display("FAIL stall_fill got=%b exp=1", valid_f_o);
    end
    snap_pc = pc_f_o;
    snap_in = instr_f_o;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 32'h0, 1'b1, 100);
      checks++;
      if (imem_req_o !== 1'b0 || pc_f_o !== snap_pc
          || instr_f_o !== snap_in) begin
        failures++;
        $display("FAIL stall_hold%0d got=%b/%h/%h exp=0/%h/%h",
                 i, imem_req_o, pc_f_o, instr_f_o,
                 snap_pc, snap_in);
      end
    end
    popped.delete();
    repeat (12) cyc(1'b0, 32'h0, 1'b0, 100);
    checks++;
    if (popped.size() < 2 || popped[0] !== snap_pc
        || popped[1] !== snap_pc + 32'd4) begin
      failures++;
      $display("FAIL stall_release n=%0d exp_first=%h",
               popped.size(), snap_pc);
    end
  endtask

  task automatic test_redirect();
    bit bad;
    test_reset();
    lat_min = 4;
    lat_max = 4;
    cyc(1'b0, 32'h0, 1'b0, 100);
    cyc(1'b0, 32'h0, 1'b0, 100);
    checks++;
    if (imem_req_o !== 1'b0) begin
      failures++;
      $display("FAIL redir_credit got=%b exp=0", imem_req_o);
    end
    cyc(1'b1, 32'h0000_0100, 1'b0, 100);
    lat_min = 1;
    lat_max = 1;
    popped.delete();
    repeat (15) cyc(1'b0, 32'h0, 1'b0, 100);
    bad = (popped.size() == 0);
    foreach (popped[i]) begin
      if (popped[i] < 32'h100 || popped[i] > 32'h1FC) bad = 1'b1;
    end
    checks++;
    if (bad || popped[0] !== 32'h100) begin
      failures++;
      $display("FAIL redir_stale n=%0d exp_first=00000100",
               popped.size());
    end
  endtask

  task automatic test_redir_rvalid_stall();
    bit found;
    test_reset();
    lat_min = 2;
    lat_max = 2;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (m_rsp.size() > 0 && m_rsp[0].due <= cyc_n
          && m_buf.size() > 0) begin
        found = 1'b1;
      end else begin
        cyc(1'b0, 32'h0, 1'b1, 100);
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL rvs_setup got=0 exp=1");
    end else begin
      cyc(1'b1, 32'h0000_0040, 1'b1, 100);
      checks++;
      if (valid_f_o !== 1'b0 || instr_f_o !== NOP_INSTR
          || pc_f_o !== 32'h0 || pcplus4_f_o !== 32'h0) begin
        failures++;
        $display("FAIL rvs_empty got=%b/%h/%h exp=0/%h/0",
                 valid_f_o, instr_f_o, pc_f_o, NOP_INSTR);
      end
    end
    repeat (8) cyc(1'b0, 32'h0, 1'b0, 100);
  endtask

`ifdef FETCH_MISALIGN_EN
  task automatic test_misalign();
    test_reset();
    lat_min = 1;
    lat_max = 1;
    repeat (4) cyc(1'b0, 32'h0, 1'b0, 100);
    cyc(1'b1, 32'h0000_0102, 1'b0, 100);
    repeat (5) cyc(1'b0, 32'h0, 1'b0, 100);
    checks++;
    if (misalign_o !== 1'b1 || imem_req_o !== 1'b0) begin
      failures++;
      $display("FAIL mis_set got=%b/%b exp=1/0",
               misalign_o, imem_req_o);
    end
    cyc(1'b1, 32'h0000_0200, 1'b0, 100);
    popped.delete();
    repeat (10) cyc(1'b0, 32'h0, 1'b0, 100);
    checks++;
    if (misalign_o !== 1'b0 || popped.size() == 0
        || popped[0] !== 32'h200) begin
      failures++;
      $display("FAIL mis_clear got=%b n=%0d exp=0 first=200",
               misalign_o, popped.size());
    end
  endtask
`endif

  task automatic test_random();
    bit          rd;
    logic [31:0] tgt;
    test_reset();
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      if (i == 750) test_reset();
      rd  = ($urandom_range(99) < 3);
      tgt = $urandom;
      cyc(rd, tgt, ($urandom_range(99) < 30), 70);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] wexp [3];
    int k;
    wexp[0] = 32'hFFFF_FFF8;
    wexp[1] = 32'hFFFF_FFFC;
    wexp[2] = 32'h0000_0000;
    @(posedge clk);
    #1;
    u2_rst_n = 1'b1;
    #1;
    checks++;
    if (u2_req !== 1'b1 || u2_addr !== 32'hFFFF_FFF8) begin
      failures++;
      $display("FAIL wrap_first got=%b/%h exp=1/fffffff8",
               u2_req, u2_addr);
    end
    k = 0;
    for (int i = 0; i < 12 && k < 3; i++) begin
      @(posedge clk);
      #2;
      if (k > 0 || u2_valid === 1'b1) begin
        checks++;
        if (u2_valid !== 1'b1 || u2_pc !== wexp[k]
            || u2_instr !== memfn(wexp[k])
            || u2_pc4 !== wexp[k] + 32'd4) begin
          failures++;
          $display("FAIL wrap_pc%0d got=%b/%h/%h exp=1/%h/%h",
                   k, u2_valid, u2_pc, u2_pc4,
                   wexp[k], wexp[k] + 32'd4);
        end
        k++;
      end
    end
    checks++;
    if (k < 3) begin
      failures++;
      $display("FAIL wrap_timeout got=%0d exp=3", k);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc_n    = 0;
    last_due = 0;
    lat_min  = 1;
    lat_max  = 1;
    m_mis    = 1'b0;
    m_pc     = 32'h0;
    u2_rst_n = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redir_rvalid_stall();
`ifdef FETCH_MISALIGN_EN
    test_misalign();
`endif
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
